clock_mode_sequencer: RTL and testbench

CLOCK_MODE_SEQUENCER -- requirements
Module: clock_mode_sequencer

---
 rtl/prop_clk_pkg.sv | 32 +++
 rtl/reset_stretch.sv | 69 ++++++
 rtl/clock_mode_sequencer.sv | 167 ++++++++++++++++
 tb/tb_clock_mode_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prop_clk_pkg.sv
// Shared definitions for the clock mode sequencer.
//   state_e       : sequencer FSM states
//   CFG_*         : bit positions inside the 8-bit clock configuration byte
//   REBOOT_HOLD   : cycles the core is held in reset during a requested reboot
//   CNT_W         : width of the shared settle/reboot down-counter
//   pll_entry_cfg : configuration applied while the PLL settles (keeps old CLKSEL)
package prop_clk_pkg;

   typedef enum logic [1:0] {
      ST_HOLD     = 2'd0,
      ST_RUN      = 2'd1,
      ST_PLL_WAIT = 2'd2,
      ST_REBOOT   = 2'd3
   } state_e;

   localparam int CFG_REBOOT     = 7;
   localparam int CFG_PLLENA     = 6;
   localparam int CFG_OSCENA     = 5;
   localparam int CFG_CLKSEL_MSB = 2;
   localparam int CFG_CLKSEL_LSB = 0;

   localparam int REBOOT_HOLD = 16;
   localparam int CNT_W       = 16;

   // While the PLL settles, everything except the clock select follows the
   // request; the divider keeps running from the previously selected source.
   function automatic logic [7:0] pll_entry_cfg(input logic [7:0] req,
                                                input logic [7:0] cur);
      return {req[7:CFG_CLKSEL_MSB+1], cur[CFG_CLKSEL_MSB:CFG_CLKSEL_LSB]};
   endfunction

endpackage

// File: rtl/reset_stretch.sv
// Synchronises the external reset request (and optionally the serial DTR line)
// into clk and produces the combined reset request for the sequencer.
//   clk        : system clock
//   rst_n      : internal active-low reset (already release-synchronised)
//   ext_resn_i : external active-low reset request, asynchronous
//   dtr_i      : serial DTR line, asynchronous; only used with DTR_RESET_EN
//   rreq_o     : reset request, active high
// Build option: DTR_RESET_EN adds the DTR synchroniser and the stretch counter
// that keeps the request asserted for RESET_STRETCH cycles after DTR rises.
module reset_stretch
   import prop_clk_pkg::*;
#(
   parameter logic [19:0] RESET_STRETCH = 20'hFFFFF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ext_resn_i,
   input  logic dtr_i,
   output logic rreq_o
);

   logic [1:0] ext_sync_q;
   logic       ext_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_sync_q <= 2'b11;
      end else begin
         ext_sync_q <= {ext_sync_q[0], ext_resn_i};
      end
   end

   assign ext_s = ext_sync_q[1];

`ifdef DTR_RESET_EN
   logic [1:0]  dtr_sync_q;
   logic        dtr_s;
   logic [19:0] stretch_q;
   logic [19:0] stretch_d;

   assign dtr_s = dtr_sync_q[1];

   always_comb begin
      stretch_d = stretch_q;
      if (!dtr_s) begin
         stretch_d = '0;
      end else if (stretch_q < RESET_STRETCH) begin
         stretch_d = stretch_q + 20'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dtr_sync_q <= 2'b00;
         stretch_q  <= '0;
      end else begin
         dtr_sync_q <= {dtr_sync_q[0], dtr_i};
         stretch_q  <= stretch_d;
      end
   end

   assign rreq_o = ~ext_s | ~dtr_s | (stretch_q < RESET_STRETCH);
`else
   logic dtr_unused;
   assign dtr_unused = dtr_i;
   assign rreq_o     = ~ext_s;
`endif

endmodule

// File: rtl/clock_mode_sequencer.sv
// Sequences clock configuration changes requested by the core onto the clock
// divider, inserting a PLL settle delay and handling reboot/reset requests.
//   clk       : 160 MHz system clock
//   nres      : asynchronous active-low reset (release synchronised internally)
//   ext_resn  : external active-low reset request, asynchronous
//   dtr       : serial DTR line, asynchronous (used only with DTR_RESET_EN)
//   cfg_req   : requested config {reboot, pllena, oscena, oscm[1:0], clksel[2:0]}
//   cfg_apply : config driven to the clock divider
//   pll_en    : PLL enable
//   core_nres : active-low core reset
//   busy      : transition in progress, cfg_req not yet reflected in cfg_apply
// Build option: DTR_RESET_EN (see reset_stretch).
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_HOLD     | reset request active; everything off, core held in reset
// ST_RUN      | normal operation; applies requested config changes
// ST_PLL_WAIT | PLL just enabled; counting down before the PLL clksel is used
// ST_REBOOT   | core held in reset for REBOOT_HOLD cycles, until reboot drops
module clock_mode_sequencer
   import prop_clk_pkg::*;
#(
   parameter logic [15:0] PLL_SETTLE    = 16'd10000,
   parameter logic [19:0] RESET_STRETCH = 20'hFFFFF
) (
   input  logic       clk,
   input  logic       nres,
   input  logic       ext_resn,
   input  logic       dtr,
   input  logic [7:0] cfg_req,
   output logic [7:0] cfg_apply,
   output logic       pll_en,
   output logic       core_nres,
   output logic       busy
);

   logic [1:0]       rst_sync_q;
   logic             rst_int_n;
   logic             rreq;

   state_e           state_q, state_d;
   logic [7:0]       cfg_q, cfg_d;
   logic             pll_q, pll_d;
   logic             nres_q, nres_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Assert asynchronously, release two edges after nres rises.
   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   reset_stretch #(
      .RESET_STRETCH (RESET_STRETCH)
   ) u_reset_stretch (
      .clk        (clk),
      .rst_n      (rst_int_n),
      .ext_resn_i (ext_resn),
      .dtr_i      (dtr),
      .rreq_o     (rreq)
   );

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      pll_d   = pll_q;
      cnt_d   = cnt_q;

      if (rreq) begin
         state_d = ST_HOLD;
         cfg_d   = '0;
         pll_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               state_d = ST_RUN;
            end

            ST_RUN: begin
               if (cfg_req != cfg_q) begin
                  if (cfg_req[CFG_REBOOT]) begin
                     state_d = ST_REBOOT;
                     cfg_d   = '0;
                     pll_d   = 1'b0;
                     cnt_d   = CNT_W'(REBOOT_HOLD - 1);
                  end else if (cfg_req[CFG_PLLENA] && !cfg_q[CFG_PLLENA]) begin
                     state_d = ST_PLL_WAIT;
                     cfg_d   = pll_entry_cfg(cfg_req, cfg_q);
                     pll_d   = 1'b1;
                     cnt_d   = PLL_SETTLE - 16'd1;
                  end else begin
                     cfg_d = cfg_req;
                     pll_d = cfg_req[CFG_PLLENA];
                  end
               end
            end

            ST_PLL_WAIT: begin
               if (cfg_req[CFG_REBOOT]) begin
                  state_d = ST_REBOOT;
                  cfg_d   = '0;
                  pll_d   = 1'b0;
                  cnt_d   = CNT_W'(REBOOT_HOLD - 1);
               end else if (!cfg_req[CFG_PLLENA]) begin
                  state_d = ST_RUN;
                  cfg_d   = cfg_req;
                  pll_d   = 1'b0;
                  cnt_d   = '0;
               end else if (cnt_q == '0) begin
                  // Apply the latest request, not the one seen on entry.
                  state_d = ST_RUN;
                  cfg_d   = cfg_req;
                  pll_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end

            ST_REBOOT: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else if (!cfg_req[CFG_REBOOT]) begin
                  state_d = ST_RUN;
               end
            end

            default: begin
               state_d = ST_HOLD;
            end
         endcase
      end

      nres_d = (state_d == ST_RUN) || (state_d == ST_PLL_WAIT);
      busy_d = (state_d != ST_RUN) || (cfg_d != cfg_req);
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q <= ST_HOLD;
         cfg_q   <= '0;
         pll_q   <= 1'b0;
         nres_q  <= 1'b0;
         busy_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         pll_q   <= pll_d;
         nres_q  <= nres_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cfg_apply = cfg_q;
   assign pll_en    = pll_q;
   assign core_nres = nres_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_clock_mode_sequencer.sv
// Bench for clock_mode_sequencer: directed scenarios followed by randomized
// config/reset traffic, all checked against a behavioural model of the
// sequencing rules. Honours DTR_RESET_EN the same way the design does.
module tb_clock_mode_sequencer;

   localparam int PLL_SETTLE     = 8;
   localparam int RESET_STRETCH  = 16;
   localparam int TB_REBOOT_HOLD = 16;

   logic       clk = 1'b0;
   logic       nres = 1'b0;
   logic       ext_resn = 1'b1;
   logic       dtr = 1'b1;
   logic [7:0] cfg_req = 8'h00;
   logic [7:0] cfg_apply;
   logic       pll_en;
   logic       core_nres;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   clock_mode_sequencer #(
      .PLL_SETTLE    (16'(PLL_SETTLE)),
      .RESET_STRETCH (20'(RESET_STRETCH))
   ) dut (
      .clk       (clk),
      .nres      (nres),
      .ext_resn  (ext_resn),
      .dtr       (dtr),
      .cfg_req   (cfg_req),
      .cfg_apply (cfg_apply),
      .pll_en    (pll_en),
      .core_nres (core_nres),
      .busy      (busy)
   );

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_age;          // edges seen since nres released
   bit         m_ext_a, m_ext_s, m_dtr_a, m_dtr_s;
   int         m_stretch;
   bit         m_in_reset;     // reset request held the sequencer
   int         m_wait_left;    // -1: no PLL settle in progress
   int         m_reboot_left;  // -1: not rebooting
   logic [7:0] m_apply;
   bit         m_pll, m_nres, m_busy;

   task automatic model_reset();
      m_age         = 0;
      m_ext_a       = 1'b1;
      m_ext_s       = 1'b1;
      m_dtr_a       = 1'b0;
      m_dtr_s       = 1'b0;
      m_stretch     = 0;
      m_in_reset    = 1'b1;
      m_wait_left   = -1;
      m_reboot_left = -1;
      m_apply       = 8'h00;
      m_pll         = 1'b0;
      m_nres        = 1'b0;
      m_busy        = 1'b1;
   endtask

   task automatic model_reboot();
      m_wait_left   = -1;
      m_reboot_left = TB_REBOOT_HOLD - 1;
      m_apply       = 8'h00;
      m_pll         = 1'b0;
      m_nres        = 1'b0;
      m_busy        = 1'b1;
   endtask

   task automatic model_step();
      bit         rreq;
      logic [7:0] c;
      c    = cfg_req;
      rreq = !m_ext_s;
`ifdef DTR_RESET_EN
      rreq = rreq || !m_dtr_s || (m_stretch < RESET_STRETCH);
      if (!m_dtr_s) m_stretch = 0;
      else if (m_stretch < RESET_STRETCH) m_stretch = m_stretch + 1;
      m_dtr_s = m_dtr_a;
      m_dtr_a = dtr;
`endif
      m_ext_s = m_ext_a;
      m_ext_a = ext_resn;

      if (rreq) begin
         m_in_reset    = 1'b1;
         m_wait_left   = -1;
         m_reboot_left = -1;
         m_apply       = 8'h00;
         m_pll         = 1'b0;
         m_nres        = 1'b0;
         m_busy        = 1'b1;
      end else if (m_in_reset) begin
         m_in_reset = 1'b0;
         m_nres     = 1'b1;
         m_busy     = (c != 8'h00);
      end else if (m_reboot_left > 0) begin
         m_reboot_left--;
      end else if (m_reboot_left == 0) begin
         if (!c[7]) begin
            m_reboot_left = -1;
            m_nres        = 1'b1;
            m_busy        = (c != 8'h00);
         end
      end else if (m_wait_left >= 0) begin
         if (c[7]) model_reboot();
         else if (!c[6] || m_wait_left == 0) begin
            m_apply     = c;
            m_pll       = c[6];
            m_busy      = 1'b0;
            m_wait_left = -1;
         end else m_wait_left--;
      end else if (c == m_apply) begin
         m_busy = 1'b0;
      end else if (c[7]) begin
         model_reboot();
      end else if (c[6] && !m_apply[6]) begin
         m_apply     = {c[7:3], m_apply[2:0]};
         m_pll       = 1'b1;
         m_busy      = 1'b1;
         m_wait_left = PLL_SETTLE - 1;
      end else begin
         m_apply = c;
         m_pll   = c[6];
         m_busy  = 1'b0;
      end
   endtask

   always @(posedge clk or negedge nres) begin
      if (!nres) model_reset();
      else if (m_age < 2) m_age++;
      else model_step();
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check_val("cfg_apply", cfg_apply, m_apply);
         check_val("pll_en", pll_en, m_pll);
         check_val("core_nres", core_nres, m_nres);
         check_val("busy", busy, m_busy);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [7:0] picks [8] = '{8'h00, 8'h6F, 8'h6E, 8'h01, 8'h80, 8'h47, 8'h2B, 8'hC0};

   initial begin
      int n;
      bit seen;
      int exp_rel;

      // reset with DTR already high
      cycles(3);
      cmp_en = 1'b1;
      check_val("rst_cfg_apply", cfg_apply, 8'h00);
      check_val("rst_core_nres", core_nres, 1'b0);
      check_val("rst_busy", busy, 1'b1);
      check_val("rst_pll_en", pll_en, 1'b0);
      #1 nres = 1'b1;
`ifdef DTR_RESET_EN
      exp_rel = RESET_STRETCH + 4;
`else
      exp_rel = 2;
`endif
      n = 0; seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (core_nres) seen = 1'b1;
         else n++;
      end
      check_val("rst_release_seen", seen, 1'b1);
      check_val("rst_release_cycles", n, exp_rel);
      cycles(2);

      // PLL enable with settle
      cfg_req = 8'h6F;
      cycles(1);
      check_val("pll_entry_apply", cfg_apply, 8'h68);
      check_val("pll_entry_pll", pll_en, 1'b1);
      check_val("pll_entry_busy", busy, 1'b1);
      cycles(7);
      check_val("pll_wait_apply", cfg_apply, 8'h68);
      cycles(1);
      check_val("pll_done_apply", cfg_apply, 8'h6F);
      check_val("pll_done_busy", busy, 1'b0);

      // change during wait does not restart the count
      cfg_req = 8'h00;
      cycles(2);
      cfg_req = 8'h6F;
      cycles(4);
      cfg_req = 8'h6E;
      cycles(4);
      check_val("norestart_wait", cfg_apply, 8'h68);
      cycles(1);
      check_val("norestart_apply", cfg_apply, 8'h6E);

      // PLL disabled mid-wait aborts
      cfg_req = 8'h00;
      cycles(2);
      cfg_req = 8'h6F;
      cycles(3);
      cfg_req = 8'h01;
      cycles(1);
      check_val("abort_apply", cfg_apply, 8'h01);
      check_val("abort_pll", pll_en, 1'b0);
      check_val("abort_busy", busy, 1'b0);

      // reboot held until request drops
      cfg_req = 8'h6F;
      cycles(10);
      check_val("pre_reboot_apply", cfg_apply, 8'h6F);
      cfg_req = 8'h80;
      cycles(1);
      check_val("reboot_nres", core_nres, 1'b0);
      check_val("reboot_apply", cfg_apply, 8'h00);
      cycles(25);
      check_val("reboot_held", core_nres, 1'b0);
      cfg_req = 8'h00;
      cycles(1);
      check_val("reboot_exit_nres", core_nres, 1'b1);
      cycles(2);

      // minimum reboot length
      cfg_req = 8'h80;
      n = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (core_nres) seen = 1'b1;
         else begin
            n++;
            cfg_req = 8'h00;
         end
      end
      check_val("reboot_min_seen", seen, 1'b1);
      check_val("reboot_min_cycles", n, TB_REBOOT_HOLD);
      cycles(2);

      // DTR glitch during PLL wait
      cfg_req = 8'h6F;
      cycles(2);
      dtr  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 0) dtr = 1'b1;
         if (!core_nres) seen = 1'b1;
      end
`ifdef DTR_RESET_EN
      check_val("dtr_glitch_hold", seen, 1'b1);
`else
      check_val("dtr_glitch_hold", seen, 1'b0);
`endif
      cycles(30);

      // randomized traffic
      for (int t = 0; t < 400; t++) begin
         int r;
         int k;
         r = $urandom_range(0, 99);
         k = $urandom_range(0, 8);
         cfg_req = (k == 8) ? 8'($urandom) : picks[k];
         if (r < 4) begin
            ext_resn = 1'b0;
            cycles($urandom_range(1, 3));
            ext_resn = 1'b1;
         end else if (r < 7) begin
            dtr = 1'b0;
            cycles($urandom_range(1, 2));
            dtr = 1'b1;
         end else if (r == 7) begin
            #1 nres = 1'b0;
            cycles(1);
            #1 nres = 1'b1;
         end
         cycles($urandom_range(1, 20));
      end

      cfg_req = 8'h00;
      cycles(40);
      check_val("final_nres", core_nres, 1'b1);
      check_val("final_apply", cfg_apply, 8'h00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
